// File: rtl/mos6502s_interrupt_sequencer_pkg.sv
// Shared definitions for the 6502 interrupt/RTI sequencer: state encoding,
// default vector addresses and status-register bit positions.
package mos6502s_interrupt_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PUSH_PCH = 4'd1,
        ST_PUSH_PCL = 4'd2,
        ST_PUSH_P   = 4'd3,
        ST_VEC_LO   = 4'd4,
        ST_VEC_HI   = 4'd5,
        ST_PULL_P   = 4'd6,
        ST_PULL_PCL = 4'd7,
        ST_PULL_PCH = 4'd8,
        ST_DONE     = 4'd9
    } seq_state_t;

    localparam logic [7:0]  STACK_PAGE_DEFAULT = 8'h01;
    localparam logic [15:0] NMI_VECTOR_DEFAULT = 16'hFFFA;
    localparam logic [15:0] IRQ_VECTOR_DEFAULT = 16'hFFFE;

    localparam int P_BIT_I = 2;
    localparam int P_BIT_B = 4;
    localparam int P_BIT_X = 5;

    // Status byte as it appears on the stack: bit 5 always set, B marks BRK.
    function automatic logic [7:0] push_status(input logic [7:0] p, input logic brk);
        logic [7:0] r;
        r          = p;
        r[P_BIT_X] = 1'b1;
        r[P_BIT_B] = brk;
        return r;
    endfunction

endpackage

// File: rtl/mos6502s_interrupt_sequencer.sv
// Multi-cycle sequencer for NMI/IRQ/BRK entry (push PC, P; fetch vector)
// and RTI (pull P, PC) over a single memory port with a ready handshake.
module mos6502s_interrupt_sequencer
    import mos6502s_interrupt_sequencer_pkg::*;
#(
    parameter logic [7:0]  STACK_PAGE = STACK_PAGE_DEFAULT,
    parameter logic [15:0] NMI_VECTOR = NMI_VECTOR_DEFAULT,
    parameter logic [15:0] IRQ_VECTOR = IRQ_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_nmi,
    input  logic        start_irq,
    input  logic        start_brk,
    input  logic        start_rti,
    input  logic [15:0] pc_in,
    input  logic [7:0]  p_in,
    input  logic [7:0]  sp_in,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] pc_out,
    output logic        pc_load,
    output logic [7:0]  sp_out,
    output logic        sp_load,
    output logic [7:0]  p_wdata,
    output logic        p_load_all,
    output logic        set_i,
    output logic        busy,
    output logic        done
);

    // Memory handshake: an access presented on mem_addr with mem_we or mem_re
    // completes in the cycle mem_ready=1; until then every output holds.

    seq_state_t  state, state_n;
    logic [15:0] pc_ret, pc_ret_n;
    logic [7:0]  p_push, p_push_n;
    logic        use_nmi, use_nmi_n;
    logic        entry, entry_n;
    logic [7:0]  sp_n, sp_up;
    logic [15:0] pc_new_n, vec;
    logic [7:0]  p_wdata_n;
    logic [15:0] addr_d;
    logic [7:0]  wdata_d;
    logic        we_d, re_d, done_d, set_i_d, p_load_all_d;

    always_comb begin
        state_n   = state;
        sp_n      = sp_out;
        pc_ret_n  = pc_ret;
        p_push_n  = p_push;
        use_nmi_n = use_nmi;
        entry_n   = entry;
        pc_new_n  = pc_out;
        p_wdata_n = p_wdata;

        case (state)
            ST_IDLE: begin
                if (start_nmi || start_irq || start_brk || start_rti) begin
                    pc_ret_n  = pc_in;
                    sp_n      = sp_in;
                    use_nmi_n = start_nmi;
                    entry_n   = start_nmi || start_irq || start_brk;
                    p_push_n  = push_status(p_in, !start_nmi && !start_irq && start_brk);
                    state_n   = entry_n ? ST_PUSH_PCH : ST_PULL_P;
                end
            end
            ST_PUSH_PCH: if (mem_ready) begin sp_n = sp_out - 8'd1; state_n = ST_PUSH_PCL; end
            ST_PUSH_PCL: if (mem_ready) begin sp_n = sp_out - 8'd1; state_n = ST_PUSH_P; end
            ST_PUSH_P:   if (mem_ready) begin sp_n = sp_out - 8'd1; state_n = ST_VEC_LO; end
            ST_VEC_LO:   if (mem_ready) begin pc_new_n[7:0]  = mem_rdata; state_n = ST_VEC_HI; end
            ST_VEC_HI:   if (mem_ready) begin pc_new_n[15:8] = mem_rdata; state_n = ST_DONE; end
            ST_PULL_P: if (mem_ready) begin
                sp_n = sp_out + 8'd1; p_wdata_n = mem_rdata; state_n = ST_PULL_PCL;
            end
            ST_PULL_PCL: if (mem_ready) begin
                sp_n = sp_out + 8'd1; pc_new_n[7:0] = mem_rdata; state_n = ST_PULL_PCH;
            end
            ST_PULL_PCH: if (mem_ready) begin
                sp_n = sp_out + 8'd1; pc_new_n[15:8] = mem_rdata; state_n = ST_DONE;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered and
        // line up with the state they belong to.
        addr_d       = 16'h0000;
        wdata_d      = 8'h00;
        we_d         = 1'b0;
        re_d         = 1'b0;
        done_d       = 1'b0;
        set_i_d      = 1'b0;
        p_load_all_d = 1'b0;
        sp_up        = sp_n + 8'd1;
        vec          = use_nmi_n ? NMI_VECTOR : IRQ_VECTOR;

        case (state_n)
            ST_PUSH_PCH: begin addr_d = {STACK_PAGE, sp_n}; wdata_d = pc_ret_n[15:8]; we_d = 1'b1; end
            ST_PUSH_PCL: begin addr_d = {STACK_PAGE, sp_n}; wdata_d = pc_ret_n[7:0];  we_d = 1'b1; end
            ST_PUSH_P:   begin addr_d = {STACK_PAGE, sp_n}; wdata_d = p_push_n;       we_d = 1'b1; end
            ST_VEC_LO:   begin addr_d = vec;          re_d = 1'b1; end
            ST_VEC_HI:   begin addr_d = vec + 16'd1;  re_d = 1'b1; end
            ST_PULL_P, ST_PULL_PCL, ST_PULL_PCH: begin
                addr_d = {STACK_PAGE, sp_up};
                re_d   = 1'b1;
            end
            ST_DONE: begin
                done_d       = 1'b1;
                set_i_d      = entry_n;
                p_load_all_d = !entry_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pc_ret     <= 16'h0000;
            p_push     <= 8'h00;
            use_nmi    <= 1'b0;
            entry      <= 1'b0;
            sp_out     <= 8'h00;
            pc_out     <= 16'h0000;
            p_wdata    <= 8'h00;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 8'h00;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            done       <= 1'b0;
            pc_load    <= 1'b0;
            sp_load    <= 1'b0;
            set_i      <= 1'b0;
            p_load_all <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            pc_ret     <= pc_ret_n;
            p_push     <= p_push_n;
            use_nmi    <= use_nmi_n;
            entry      <= entry_n;
            sp_out     <= sp_n;
            pc_out     <= pc_new_n;
            p_wdata    <= p_wdata_n;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
            mem_we     <= we_d;
            mem_re     <= re_d;
            done       <= done_d;
            pc_load    <= done_d;
            sp_load    <= done_d;
            set_i      <= set_i_d;
            p_load_all <= p_load_all_d;
            busy       <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_mos6502s_interrupt_sequencer.sv
// Directed and randomized bench for the interrupt sequencer; expected stack
// writes and memory reads are queued at stimulus time and checked as they occur.
module tb_mos6502s_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_nmi, start_irq, start_brk, start_rti;
    logic [15:0] pc_in;
    logic [7:0]  p_in, sp_in;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we, mem_re, mem_ready;
    logic [15:0] pc_out;
    logic        pc_load, sp_load, p_load_all, set_i, busy, done;
    logic [7:0]  sp_out, p_wdata;

    logic [7:0]  mem [0:65535];
    logic [23:0] exp_wr_q[$];
    logic [15:0] exp_rd_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    mos6502s_interrupt_sequencer dut (
        .clk(clk), .rst(rst),
        .start_nmi(start_nmi), .start_irq(start_irq), .start_brk(start_brk), .start_rti(start_rti),
        .pc_in(pc_in), .p_in(p_in), .sp_in(sp_in),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_out(pc_out), .pc_load(pc_load), .sp_out(sp_out), .sp_load(sp_load),
        .p_wdata(p_wdata), .p_load_all(p_load_all), .set_i(set_i), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completed access must match the head of its queue.
    always @(negedge clk) begin
        if (!rst && mem_ready && (mem_we || mem_re)) begin
            chk("we_re_exclusive", {31'd0, mem_we & mem_re}, 32'd0);
            if (mem_we) begin
                if (exp_wr_q.size() == 0) chk("unexpected_write", {8'h00, mem_addr, mem_wdata}, 32'hFFFFFFFF);
                else chk("write", {8'h00, mem_addr, mem_wdata}, {8'h00, exp_wr_q.pop_front()});
            end
            if (mem_re) begin
                if (exp_rd_q.size() == 0) chk("unexpected_read", {16'h0000, mem_addr}, 32'hFFFFFFFF);
                else chk("read_addr", {16'h0000, mem_addr}, {16'h0000, exp_rd_q.pop_front()});
            end
        end
    end

    task automatic exp_entry(input logic [15:0] pc, input logic [7:0] p, input logic [7:0] sp,
                             input logic brk, input logic [15:0] vec);
        logic [7:0] s;
        logic [7:0] pp;
        pp = ((p | 8'h20) & 8'hEF) | (brk ? 8'h10 : 8'h00);
        s = sp;          exp_wr_q.push_back({8'h01, s, pc[15:8]});
        s = s - 8'd1;    exp_wr_q.push_back({8'h01, s, pc[7:0]});
        s = s - 8'd1;    exp_wr_q.push_back({8'h01, s, pp});
        exp_rd_q.push_back(vec);
        exp_rd_q.push_back(vec + 16'd1);
    endtask

    task automatic exp_rti(input logic [7:0] sp);
        logic [7:0] s;
        s = sp + 8'd1; exp_rd_q.push_back({8'h01, s});
        s = s + 8'd1;  exp_rd_q.push_back({8'h01, s});
        s = s + 8'd1;  exp_rd_q.push_back({8'h01, s});
    endtask

    // Pulses the requested start(s), optionally injects a late start_irq, and
    // counts edges until done; exp_lat <= 0 only bounds the wait.
    task automatic run(input logic [3:0] req, input int exp_lat, input int irq_at,
                       input logic rand_ready, input string tag);
        int lat;
        lat = 0;
        {start_nmi, start_irq, start_brk, start_rti} = req;
        for (int i = 1; i <= 200 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (i == 1) {start_nmi, start_irq, start_brk, start_rti} = 4'b0000;
            if (i == irq_at) start_irq = 1'b1;
            else if (i == irq_at + 1) start_irq = 1'b0;
            if (done) lat = i;
            else if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
        end
        start_irq = 1'b0;
        mem_ready = 1'b1;
        if (exp_lat > 0) chk({tag, "_latency"}, lat, exp_lat);
        else chk({tag, "_no_timeout"}, {31'd0, lat > 0}, 32'd1);
    endtask

    task automatic check_done(input string tag, input logic [15:0] pc, input logic [7:0] sp,
                              input logic is_entry, input logic [7:0] p);
        chk({tag, "_pc_out"}, pc_out, pc);
        chk({tag, "_sp_out"}, sp_out, sp);
        chk({tag, "_load_strobes"}, {pc_load, sp_load}, 2'b11);
        chk({tag, "_set_i"}, set_i, is_entry);
        chk({tag, "_p_load_all"}, p_load_all, !is_entry);
        if (!is_entry) chk({tag, "_p_wdata"}, p_wdata, p);
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, {done, pc_load, sp_load, set_i, p_load_all, busy}, 6'b0);
        chk({tag, "_wr_q_drained"}, exp_wr_q.size(), 0);
        chk({tag, "_rd_q_drained"}, exp_rd_q.size(), 0);
    endtask

    initial begin
        logic [15:0] rpc;
        logic [7:0]  rp, rsp, lo, hi;

        rst = 1'b1;
        {start_nmi, start_irq, start_brk, start_rti} = 4'b0000;
        pc_in = 16'h0000; p_in = 8'h00; sp_in = 8'h00; mem_ready = 1'b1;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_strobes", {mem_we, mem_re, pc_load, sp_load, p_load_all, set_i, done, busy}, 8'h00);
        chk("reset_pc_out", pc_out, 16'h0000);
        chk("reset_sp_out", sp_out, 8'h00);
        chk("reset_p_wdata", p_wdata, 8'h00);
        chk("reset_mem_wdata", mem_wdata, 8'h00);
        chk("reset_mem_addr", mem_addr, 16'h0000);
        rst = 1'b0;
        @(posedge clk); #1;

        // IRQ entry
        mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h80;
        pc_in = 16'h1234; p_in = 8'h81; sp_in = 8'hFD;
        exp_entry(16'h1234, 8'h81, 8'hFD, 1'b0, 16'hFFFE);
        run(4'b0100, 6, -1, 1'b0, "irq");
        check_done("irq", 16'h8000, 8'hFA, 1'b1, 8'h00);

        // BRK entry
        exp_entry(16'h1234, 8'h81, 8'hFD, 1'b1, 16'hFFFE);
        run(4'b0010, 6, -1, 1'b0, "brk");
        check_done("brk", 16'h8000, 8'hFA, 1'b1, 8'h00);

        // RTI
        mem[16'h01FB] = 8'hC3; mem[16'h01FC] = 8'h34; mem[16'h01FD] = 8'h12;
        sp_in = 8'hFA;
        exp_rti(8'hFA);
        run(4'b0001, 4, -1, 1'b0, "rti");
        check_done("rti", 16'h1234, 8'hFD, 1'b0, 8'hC3);

        // NMI beats IRQ; a start_irq while busy is dropped
        mem[16'hFFFA] = 8'h11; mem[16'hFFFB] = 8'h22;
        sp_in = 8'hFD;
        exp_entry(16'h1234, 8'h81, 8'hFD, 1'b0, 16'hFFFA);
        run(4'b1100, 6, 3, 1'b0, "prio");
        check_done("prio", 16'h2211, 8'hFA, 1'b1, 8'h00);
        repeat (6) @(posedge clk);
        #1;
        chk("busy_irq_ignored", {busy, done}, 2'b00);

        // Stack pointer wrap on entry and RTI
        pc_in = 16'hBEEF; p_in = 8'h00; sp_in = 8'h01;
        exp_entry(16'hBEEF, 8'h00, 8'h01, 1'b0, 16'hFFFE);
        run(4'b0100, 6, -1, 1'b0, "wrap_entry");
        check_done("wrap_entry", 16'h8000, 8'hFE, 1'b1, 8'h00);
        mem[16'h01FF] = 8'h5A; mem[16'h0100] = 8'h78; mem[16'h0101] = 8'h56;
        sp_in = 8'hFE;
        exp_rti(8'hFE);
        run(4'b0001, 4, -1, 1'b0, "wrap_rti");
        check_done("wrap_rti", 16'h5678, 8'h01, 1'b0, 8'h5A);

        // Randomized entry/RTI pairs with random memory stalls
        for (int k = 0; k < 4; k++) begin
            rpc = 16'($urandom_range(0, 65535));
            rp  = 8'($urandom_range(0, 255));
            rsp = 8'($urandom_range(0, 255));
            lo  = 8'($urandom_range(0, 255));
            hi  = 8'($urandom_range(0, 255));
            mem[16'hFFFE] = lo; mem[16'hFFFF] = hi;
            pc_in = rpc; p_in = rp; sp_in = rsp;
            exp_entry(rpc, rp, rsp, 1'b0, 16'hFFFE);
            run(4'b0100, -1, -1, 1'b1, "rand_irq");
            check_done("rand_irq", {hi, lo}, rsp - 8'd3, 1'b1, 8'h00);
            mem[{8'h01, rsp + 8'd1}] = rp;
            mem[{8'h01, rsp + 8'd2}] = rpc[7:0];
            mem[{8'h01, rsp + 8'd3}] = rpc[15:8];
            exp_rti(rsp);
            run(4'b0001, -1, -1, 1'b1, "rand_rti");
            check_done("rand_rti", rpc, rsp + 8'd3, 1'b0, rp);
        end

        // Stall in PUSH_PCL holds the access; reset in VEC_LO aborts
        pc_in = 16'h1234; p_in = 8'h81; sp_in = 8'hFD;
        exp_wr_q.push_back({16'h01FD, 8'h12});
        exp_wr_q.push_back({16'h01FC, 8'h34});
        exp_wr_q.push_back({16'h01FB, 8'hA1});
        start_irq = 1'b1;
        @(posedge clk); #1;
        start_irq = 1'b0;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            chk("stall_hold", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h01FC, 8'h34});
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("vec_lo_addr", {mem_re, mem_addr}, {1'b1, 16'hFFFE});
        rst = 1'b1;
        #1;
        chk("abort_strobes", {mem_we, mem_re, pc_load, sp_load, done, busy}, 6'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int s = 0; s < 6; s++) begin
            @(posedge clk); #1;
            chk("abort_quiet", {done, pc_load, busy, mem_re, mem_we}, 5'b0);
        end
        chk("abort_wr_q_drained", exp_wr_q.size(), 0);
        chk("abort_rd_q_drained", exp_rd_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
